// File: rtl/lcd_pkg.sv
// Shared command codes, image and window sizes, and sequencer states for lcd_cmd_sequencer.
package lcd_pkg;

    localparam logic [2:0] CMD_LOAD     = 3'd0;
    localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
    localparam logic [2:0] CMD_ZOOM_FIT = 3'd2;
    localparam logic [2:0] CMD_SHIFT_R  = 3'd3;
    localparam logic [2:0] CMD_SHIFT_L  = 3'd4;
    localparam logic [2:0] CMD_SHIFT_U  = 3'd5;
    localparam logic [2:0] CMD_SHIFT_D  = 3'd6;
    localparam logic [2:0] CMD_ILLEGAL  = 3'd7;

    localparam int IMAGE_N_DEFAULT     = 108;
    localparam int OUT_PER_CMD_DEFAULT = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, LOAD, WAIT} seq_state_t;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Small synchronous FIFO for host commands; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate occupancy counter.
module seq_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Issues queued host commands to LCD_CTRL one at a time, streams image bytes for loads,
// and tracks window outputs per command for completion and timeout reporting.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int IMAGE_N     = IMAGE_N_DEFAULT,
    parameter int OUT_PER_CMD = OUT_PER_CMD_DEFAULT,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_cmd_valid,
    output logic       host_cmd_ready,
    output logic [6:0] img_addr,
    output logic       img_rd,
    input  logic [7:0] img_data,
    output logic [2:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    output logic [7:0] lcd_datain,
    input  logic       lcd_busy,
    input  logic       lcd_output_valid,
    output logic       cmd_done,
    output logic       err_badcmd,
    output logic       err_timeout,
    output logic       idle
);

    localparam logic [6:0] LAST_BYTE   = 7'(IMAGE_N - 1);
    localparam logic [4:0] OUT_TARGET  = 5'(OUT_PER_CMD);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    seq_state_t state;
    logic [6:0] byte_cnt;
    logic [4:0] out_cnt;
    logic [7:0] idle_cnt;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_dout;
    logic       done_now;

    seq_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (host_cmd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign host_cmd_ready = !reset && !fifo_full;
    assign fifo_push      = host_cmd_valid && host_cmd_ready;
    assign fifo_pop       = (state == IDLE) && !fifo_empty && !lcd_busy;
    assign idle           = (state == IDLE) && fifo_empty;
    assign lcd_datain     = (state == LOAD) ? img_data : 8'h00;

    // Completion is decoded from the registered window count so it lands the cycle
    // after the last output; the FSM returns to IDLE on the same edge.
    assign done_now = (state == WAIT) && (out_cnt == OUT_TARGET) && !lcd_busy;
    assign cmd_done = done_now && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            out_cnt       <= '0;
            idle_cnt      <= '0;
            img_addr      <= '0;
            img_rd        <= 1'b0;
            lcd_cmd       <= '0;
            lcd_cmd_valid <= 1'b0;
            err_badcmd    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            lcd_cmd       <= '0;
            lcd_cmd_valid <= 1'b0;
            err_badcmd    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        if (fifo_dout == CMD_ILLEGAL) begin
                            err_badcmd <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            lcd_cmd       <= fifo_dout;
                            lcd_cmd_valid <= 1'b1;
                            if (fifo_dout == CMD_LOAD) begin
                                img_rd   <= 1'b1;
                                img_addr <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    byte_cnt <= '0;
                    out_cnt  <= '0;
                    idle_cnt <= '0;
                    if (lcd_cmd == CMD_LOAD) begin
                        state    <= LOAD;
                        img_rd   <= 1'b1;
                        img_addr <= 7'd1;
                    end else begin
                        state <= WAIT;
                    end
                end
                // Reads run one address ahead so each byte arrives exactly when it is forwarded.
                LOAD: begin
                    if (byte_cnt == LAST_BYTE) begin
                        state    <= WAIT;
                        idle_cnt <= '0;
                        img_rd   <= 1'b0;
                        img_addr <= '0;
                    end else begin
                        byte_cnt <= byte_cnt + 7'd1;
                        if (byte_cnt + 7'd1 < LAST_BYTE) begin
                            img_rd   <= 1'b1;
                            img_addr <= byte_cnt + 7'd2;
                        end else begin
                            img_rd   <= 1'b0;
                            img_addr <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (done_now) begin
                        state <= IDLE;
                    end else if (!lcd_output_valid && (idle_cnt + 8'd1 == TIMEOUT_CNT)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (lcd_output_valid) begin
                        idle_cnt <= '0;
                        if (out_cnt != OUT_TARGET) begin
                            out_cnt <= out_cnt + 5'd1;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
